// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared constants and types for the data-memory responder.
//   WORD_W   : CPU data word width.
//   MAX_WAIT : largest legal WAIT_STATES value; sizes the wait counter.
//   CNT_W    : wait-counter width derived from MAX_WAIT.
//   dmem_state_e : responder FSM states IDLE / WAIT / DONE.
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int WORD_W   = 16;
    localparam int MAX_WAIT = 15;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// CPU data-memory port bundle.
//   dmemaddr/dmemwdata/dmemwrite/dmemread : CPU -> responder request.
//   dmemrdata/dmemvalid/dmemstall         : responder -> CPU response.
//   dmemerror : sticky misaligned/out-of-range flag, present only when
//               DMEM_ALIGN_CHECK_EN is defined.
// Modports: master = CPU side, slave = responder side.
// -----------------------------------------------------------------------------
interface dmem_responder_if;
    import dmem_pkg::*;

    logic [WORD_W-1:0] dmemaddr;
    logic [WORD_W-1:0] dmemwdata;
    logic              dmemwrite;
    logic              dmemread;
    logic [WORD_W-1:0] dmemrdata;
    logic              dmemvalid;
    logic              dmemstall;
`ifdef DMEM_ALIGN_CHECK_EN
    logic              dmemerror;

    modport master (
        output dmemaddr, dmemwdata, dmemwrite, dmemread,
        input  dmemrdata, dmemvalid, dmemstall, dmemerror
    );
    modport slave (
        input  dmemaddr, dmemwdata, dmemwrite, dmemread,
        output dmemrdata, dmemvalid, dmemstall, dmemerror
    );
`else
    modport master (
        output dmemaddr, dmemwdata, dmemwrite, dmemread,
        input  dmemrdata, dmemvalid, dmemstall
    );
    modport slave (
        input  dmemaddr, dmemwdata, dmemwrite, dmemread,
        output dmemrdata, dmemvalid, dmemstall
    );
`endif

endinterface

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Single-port word array: synchronous write, asynchronous read.
// Contents are not reset.
//   clock : write clock (rising edge)
//   we    : write enable
//   addr  : word index shared by read and write
//   wdata : write data
//   rdata : combinational read of mem[addr]
// -----------------------------------------------------------------------------
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clock,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WORD_W-1:0]    wdata,
    output logic [WORD_W-1:0]    rdata
);

    logic [WORD_W-1:0] mem_r [2**ADDR_BITS];

    // Write port: commit one word on the enabled clock edge.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Fixed-latency data-memory responder for the pipelined 16-bit CPU.
// A request seen in IDLE stalls the CPU for WAIT_STATES+1 cycles, then one
// DONE cycle completes it (write committed / read data presented with
// dmemvalid). Address bit 0 and bits above ADDR_BITS are ignored (aliasing).
//   clock : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : dmem_responder_if.slave (request in, rdata/valid/stall out)
// Parameters: ADDR_BITS (word-index width), WAIT_STATES (0..15).
// Optional: DMEM_ALIGN_CHECK_EN adds sticky dmemerror; misaligned or
// out-of-range accesses drop writes and read back as 0.
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic             clock,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_WAIT = WAIT;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]           state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [WORD_W-1:0]    addr_r;
    logic [WORD_W-1:0]    wdata_r;
    logic                 write_r;
    logic [WORD_W-1:0]    rdata_r;
    logic                 valid_r;

    logic                 req_s;
    logic [WORD_W-1:0]    acc_addr_s;
    logic [WORD_W-1:0]    acc_wdata_s;
    logic                 acc_write_s;
    logic [ADDR_BITS-1:0] acc_idx_s;
    logic                 done_entry_s;
    logic                 commit_ok_s;
    logic                 we_s;
    logic [WORD_W-1:0]    mem_rdata_s;
    logic                 stall_s;

    assign req_s = bus.dmemread | bus.dmemwrite;

    // Access operands: live inputs in IDLE (so a zero-wait access can commit
    // on the latching edge), latched copies once the access is under way.
    always_comb begin
        acc_addr_s  = addr_r;
        acc_wdata_s = wdata_r;
        acc_write_s = write_r;
        if (state_r == ST_IDLE) begin
            acc_addr_s  = bus.dmemaddr;
            acc_wdata_s = bus.dmemwdata;
            acc_write_s = bus.dmemwrite;
        end else begin
            acc_addr_s  = addr_r;
            acc_wdata_s = wdata_r;
            acc_write_s = write_r;
        end
    end

    assign acc_idx_s = acc_addr_s[ADDR_BITS:1];

    // Marks the edge that moves the FSM into DONE (the access completes here).
    always_comb begin
        done_entry_s = 1'b0;
        case (state_r)
            ST_IDLE: done_entry_s = req_s && (WAIT_STATES == 0);
            ST_WAIT: done_entry_s = (cnt_r <= CNT_W'(1));
            default: done_entry_s = 1'b0;
        endcase
    end

`ifdef DMEM_ALIGN_CHECK_EN
    logic addr_bad_s;
    logic err_r;

    assign addr_bad_s  = acc_addr_s[0] | (|(acc_addr_s >> (ADDR_BITS + 1)));
    assign commit_ok_s = ~addr_bad_s;

    // Sticky error flag, visible from the DONE cycle of the offending access.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (done_entry_s && addr_bad_s) begin
            err_r <= 1'b1;
        end
    end

    assign bus.dmemerror = err_r;
`else
    logic addr_unused_s;

    assign addr_unused_s = ^{acc_addr_s[WORD_W-1:ADDR_BITS+1], acc_addr_s[0]};
    assign commit_ok_s   = 1'b1;
`endif

    // The array has no reset, so a write is also blocked while reset is high.
    assign we_s = done_entry_s & acc_write_s & commit_ok_s & ~reset;

    dmem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clock (clock),
        .we    (we_s),
        .addr  (acc_idx_s),
        .wdata (acc_wdata_s),
        .rdata (mem_rdata_s)
    );

    // FSM, wait counter, request latches and registered read response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_W'(0);
            addr_r  <= WORD_W'(0);
            wdata_r <= WORD_W'(0);
            write_r <= 1'b0;
            rdata_r <= WORD_W'(0);
            valid_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        addr_r  <= bus.dmemaddr;
                        wdata_r <= bus.dmemwdata;
                        write_r <= bus.dmemwrite;
                        cnt_r   <= CNT_W'(WAIT_STATES);
                        state_r <= (WAIT_STATES == 0) ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r != CNT_W'(0)) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                    if (done_entry_s) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
            // Write wins over read, so only a pure read produces data.
            if (done_entry_s && !acc_write_s) begin
                rdata_r <= commit_ok_s ? mem_rdata_s : WORD_W'(0);
                valid_r <= 1'b1;
            end
        end
    end

    // Stall is combinational in IDLE so the CPU freezes in the request cycle.
    always_comb begin
        stall_s = 1'b0;
        if (reset) begin
            stall_s = 1'b0;
        end else begin
            stall_s = ((state_r == ST_IDLE) && req_s) || (state_r == ST_WAIT);
        end
    end

    assign bus.dmemstall = stall_s;
    assign bus.dmemvalid = valid_r;
    assign bus.dmemrdata = rdata_r;

endmodule
